// File: rtl/fp_acc_seq_if.sv
// Operand stream, adder hookup and result bus for fp_acc_seq.
// FP_ACC_SEQ_OVF_EN adds the sticky ovf flag to the bus.
interface fp_acc_seq_if #(
    parameter int N     = 32,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic [N-1:0]     add_res;
    logic             busy;
    logic             done;
    logic [N-1:0]     sum;
`ifdef FP_ACC_SEQ_OVF_EN
    logic             ovf;

    modport slave (
        input  start, len, in_valid, in_data, add_res,
        output in_ready, add_a, add_b, busy, done, sum, ovf
    );
    modport master (
        output start, len, in_valid, in_data, add_res,
        input  in_ready, add_a, add_b, busy, done, sum, ovf
    );
`else
    modport slave (
        input  start, len, in_valid, in_data, add_res,
        output in_ready, add_a, add_b, busy, done, sum
    );
    modport master (
        output start, len, in_valid, in_data, add_res,
        input  in_ready, add_a, add_b, busy, done, sum
    );
`endif
endinterface

// File: rtl/fp_acc_seq.sv
// Sequential binary32 accumulator wrapped around an external combinational adder.
// Optional sticky exponent-overflow flag enabled by FP_ACC_SEQ_OVF_EN.
module fp_acc_seq #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    fp_acc_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     acc, acc_nxt, acc_upd;
    logic [N-1:0]     sum_q, sum_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, in_zero, acc_zero, cancel, acc_wr;

    assign accept   = bus.in_valid && bus.in_ready;
    assign in_zero  = (bus.in_data[30:0] == 31'd0);
    assign acc_zero = (acc[30:0] == 31'd0);
    assign cancel   = (acc[30:0] == bus.in_data[30:0]) && (acc[31] != bus.in_data[31]);

    // The adder cannot handle zero operands or a zero result, so those cases bypass it.
    always_comb begin
        acc_upd = bus.add_res;
        acc_wr  = 1'b1;
        if (in_zero) begin
            acc_upd = acc;
            acc_wr  = 1'b0;
        end else if (acc_zero) begin
            acc_upd = bus.in_data;
        end else if (cancel) begin
            acc_upd = '0;
        end
    end

`ifdef FP_ACC_SEQ_OVF_EN
    logic ovf_q, ovf_nxt;
`endif

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sum_nxt   = sum_q;
`ifdef FP_ACC_SEQ_OVF_EN
        ovf_nxt   = ovf_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef FP_ACC_SEQ_OVF_EN
                    ovf_nxt = 1'b0;
`endif
                    if (bus.len != '0) begin
                        cnt_nxt   = bus.len;
                        state_nxt = FIRST;
                    end else begin
                        acc_nxt   = '0;
                        state_nxt = DONE;
                    end
                end
            end
            FIRST: begin
                if (accept) begin
                    acc_nxt   = bus.in_data;
                    cnt_nxt   = cnt - CNT_W'(1);
                    state_nxt = (cnt == CNT_W'(1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = acc_upd;
                    cnt_nxt = cnt - CNT_W'(1);
`ifdef FP_ACC_SEQ_OVF_EN
                    if (acc_wr && acc_upd[30:23] == 8'hFF) ovf_nxt = 1'b1;
`endif
                    if (cnt == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                sum_nxt   = acc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sum_q <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sum_q <= sum_nxt;
        end
    end

`ifdef FP_ACC_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_nxt;
    end
    assign bus.ovf = ovf_q;
`endif

    assign bus.add_a    = acc;
    assign bus.add_b    = bus.in_data;
    assign bus.in_ready = (state == FIRST) || (state == ACCUM);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
endmodule
